// File: rtl/mult_div_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// master drives operations and MTHI/MTLO writes; slave returns HI/LO and status.
interface mult_div_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] rs_data;
   logic [WIDTH-1:0] rt_data;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;

   modport master (
      output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
      input  hi, lo, busy, done
   );

   modport slave (
      input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
      output hi, lo, busy, done
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Works on operand magnitudes for WIDTH cycles, then applies sign correction.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input logic       clk,
   input logic       rst,
   mult_div_if.slave bus
);

   localparam int W2 = 2 * WIDTH;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_SIGN = 2'd2;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   logic [1:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic             r_is_div;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_div0;
   logic [W2-1:0]    r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [W2-1:0]    r_prod;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dvsr;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_busy;
   logic             r_done;

   logic             w_signed_op;
   logic             w_rs_neg;
   logic             w_rt_neg;
   logic [WIDTH-1:0] w_rs_mag;
   logic [WIDTH-1:0] w_rt_mag;
   logic [WIDTH:0]   w_shift;
   logic             w_fits;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_quo_nxt;
   logic [W2-1:0]    w_prod_nxt;
   logic [W2-1:0]    w_prod_fin;
   logic [WIDTH-1:0] w_quo_fin;
   logic [WIDTH-1:0] w_rem_fin;

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
      return en ? (~v + WIDTH'(1)) : v;
   endfunction

   function automatic logic [W2-1:0] neg_w2(input logic [W2-1:0] v, input logic en);
      return en ? (~v + W2'(1)) : v;
   endfunction

   // Operand decode: signed ops (MULT, DIV) have op[0] == 0
   always_comb begin
      w_signed_op = ~bus.op[0];
      w_rs_neg    = w_signed_op & bus.rs_data[WIDTH-1];
      w_rt_neg    = w_signed_op & bus.rt_data[WIDTH-1];
      w_rs_mag    = neg_w(bus.rs_data, w_rs_neg);
      w_rt_mag    = neg_w(bus.rt_data, w_rt_neg);
   end

   // One restoring-division step and one shift-add multiply step per cycle
   always_comb begin
      w_shift    = {r_rem, r_quo[WIDTH-1]};
      w_fits     = (w_shift >= {1'b0, r_dvsr});
      w_rem_nxt  = w_fits ? (w_shift[WIDTH-1:0] - r_dvsr) : w_shift[WIDTH-1:0];
      w_quo_nxt  = {r_quo[WIDTH-2:0], w_fits};
      w_prod_nxt = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
   end

   // Sign correction; a zero divisor leaves the all-ones quotient untouched
   always_comb begin
      w_prod_fin = neg_w2(r_prod, r_neg_q);
      w_quo_fin  = r_div0 ? {WIDTH{1'b1}} : neg_w(r_quo, r_neg_q);
      w_rem_fin  = neg_w(r_rem, r_neg_r);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvsr   <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;

         // MTHI/MTLO only while idle; a same-edge start is overwritten later by the result
         if (!r_busy && bus.hi_we) r_hi <= bus.wdata;
         if (!r_busy && bus.lo_we) r_lo <= bus.wdata;

         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state  <= S_RUN;
                  r_busy   <= 1'b1;
                  r_cnt    <= '0;
                  r_is_div <= (bus.op == OP_DIV) || (bus.op == OP_DIVU);
                  r_neg_q  <= w_rs_neg ^ w_rt_neg;
                  r_neg_r  <= w_rs_neg;
                  r_div0   <= ((bus.op == OP_DIV) || (bus.op == OP_DIVU)) &&
                              (bus.rt_data == '0);
                  r_mcand  <= {{WIDTH{1'b0}}, w_rs_mag};
                  r_mplier <= w_rt_mag;
                  r_prod   <= '0;
                  r_rem    <= '0;
                  r_quo    <= w_rs_mag;
                  r_dvsr   <= w_rt_mag;
               end
            end

            S_RUN: begin
               r_cnt <= r_cnt + CW'(1);
               if (r_is_div) begin
                  r_rem <= w_rem_nxt;
                  r_quo <= w_quo_nxt;
               end else begin
                  r_prod   <= w_prod_nxt;
                  r_mcand  <= {r_mcand[W2-2:0], 1'b0};
                  r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
               end
               if (r_cnt == LAST_CNT) r_state <= S_SIGN;
            end

            S_SIGN: begin
               if (r_is_div) begin
                  r_hi <= w_rem_fin;
                  r_lo <= w_quo_fin;
               end else begin
                  r_hi <= w_prod_fin[W2-1:WIDTH];
                  r_lo <= w_prod_fin[WIDTH-1:0];
               end
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;
   assign bus.busy = r_busy;
   assign bus.done = r_done;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: vector table, random ops against an arithmetic model,
// and hand-written sequences for MTHI/MTLO, ignored starts and mid-op reset.
module tb_mult_div_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mult_div_if #(.WIDTH(32)) bus ();

   mult_div_unit #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   int total = 0;
   int bad   = 0;
   logic [63:0] sb[$];
   vec_t vecs[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb_, q, r;
      logic [63:0] ua, ub;
      sa = longint'($signed(a));
      sb_ = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (op)
         2'b00: return 64'(sa * sb_);
         2'b01: return ua * ub;
         2'b10: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sb_;
            r = sa % sb_;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {32'(ua % ub), 32'(ua / ub)};
         end
      endcase
   endfunction

   // act: 0 none, 1 second start at mid_cyc, 2 MTHI attempt at mid_cyc
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int mid_cyc, input int act,
                         input bit same_hi);
      int lat;
      int nbusy;
      bit got;
      logic [31:0] hold;
      logic [63:0] expv;
      @(negedge clk);
      bus.start   = 1'b1;
      bus.op      = op;
      bus.rs_data = a;
      bus.rt_data = b;
      if (same_hi) begin
         bus.hi_we = 1'b1;
         bus.wdata = 32'h5A5A_5A5A;
      end
      sb.push_back(exp);
      @(posedge clk);
      lat = 0;
      nbusy = 0;
      got = 1'b0;
      hold = '0;
      while (!got && lat < 60) begin
         @(negedge clk);
         bus.start = 1'b0;
         bus.hi_we = 1'b0;
         bus.lo_we = 1'b0;
         if (lat == 0) begin
            bus.rs_data = $urandom;
            bus.rt_data = $urandom;
            if (same_hi) chk("mthi_same_edge", {32'b0, bus.hi}, 64'h5A5A_5A5A);
         end
         if (act == 2 && lat == mid_cyc + 1) chk("mthi_while_busy", {32'b0, bus.hi}, {32'b0, hold});
         if (bus.done) begin
            got = 1'b1;
            chk("busy_at_done", {63'b0, bus.busy}, 64'd0);
         end else begin
            if (bus.busy) nbusy++;
            if (act == 1 && lat == mid_cyc) begin
               bus.start   = 1'b1;
               bus.op      = 2'b01;
               bus.rs_data = 32'd3;
               bus.rt_data = 32'd3;
            end
            if (act == 2 && lat == mid_cyc) begin
               hold      = bus.hi;
               bus.hi_we = 1'b1;
               bus.wdata = 32'hDEAD_BEEF;
            end
            @(posedge clk);
            lat++;
         end
      end
      expv = (sb.size() > 0) ? sb.pop_front() : 64'd0;
      if (!got) chk("done_timeout", 64'd0, 64'd1);
      else chk("result", {bus.hi, bus.lo}, expv);
      chk("latency", 64'(lat), 64'd33);
      chk("busy_cycles", 64'(nbusy), 64'd33);
      @(negedge clk);
      chk("done_one_cycle", {62'b0, bus.done, bus.busy}, 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, b;
      logic [1:0]  op;

      vecs[0]  = '{2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
      vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vecs[4]  = '{2'b11, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
      vecs[5]  = '{2'b10, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'hFFFF_FFFF};
      vecs[6]  = '{2'b00, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[7]  = '{2'b00, 32'd0,         32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000};
      vecs[8]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
      vecs[9]  = '{2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
      vecs[10] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vecs[11] = '{2'b10, 32'd0,         32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000};
      vecs[12] = '{2'b11, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF};
      vecs[13] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

      bus.start   = 1'b0;
      bus.op      = 2'b00;
      bus.rs_data = '0;
      bus.rt_data = '0;
      bus.hi_we   = 1'b0;
      bus.lo_we   = 1'b0;
      bus.wdata   = '0;

      repeat (3) @(negedge clk);
      chk("reset_state", {bus.hi, bus.lo}, 64'd0);
      chk("reset_flags", {62'b0, bus.busy, bus.done}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("after_reset", {bus.hi, bus.lo}, 64'd0);

      // MTLO / MTHI while idle
      bus.lo_we = 1'b1;
      bus.wdata = 32'h0000_1234;
      @(negedge clk);
      bus.lo_we = 1'b0;
      chk("mtlo_idle", {32'b0, bus.lo}, 64'h1234);
      bus.hi_we = 1'b1;
      bus.wdata = 32'h0000_ABCD;
      @(negedge clk);
      bus.hi_we = 1'b0;
      chk("mthi_idle", {bus.hi, bus.lo}, 64'h0000_ABCD_0000_1234);

      foreach (vecs[i])
         run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, {vecs[i].hi, vecs[i].lo}, 0, 0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         op = 2'(i);
         a  = $urandom;
         b  = (i == 6) ? 32'd0 : $urandom;
         run_op(op, a, b, model(op, a, b), 0, 0, 1'b0);
      end

      // Second start mid-op is ignored
      run_op(2'b11, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 10, 1, 1'b0);
      // MTHI while busy is dropped
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5, 2, 1'b0);
      // MTHI on the start edge lands, then the result overwrites it
      run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 0, 0, 1'b1);

      // Asynchronous reset in the middle of a MULTU
      @(negedge clk);
      bus.start   = 1'b1;
      bus.op      = 2'b01;
      bus.rs_data = 32'hFFFF_FFFF;
      bus.rt_data = 32'hFFFF_FFFF;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      chk("busy_before_abort", {63'b0, bus.busy}, 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("abort_flags", {62'b0, bus.busy, bus.done}, 64'd0);
      chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 1'b0);

      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
